// File: rtl/fpu_pkg.sv
// Shared FPU definitions: special encodings, the packed single-precision view,
// the sequencer state set and operand classification helpers.
package fpu_pkg;

    localparam logic [31:0] FP_NAN     = 32'h7F80_0001;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam int          FP_BIAS    = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPECIAL = 3'd1,
        MUL     = 3'd2,
        NORM    = 3'd3,
        DONE    = 3'd4
    } mul_state_t;

    // Denormals have exponent field 0 and are flushed to zero.
    function automatic logic fp_is_zero(input fp32_t v);
        return v.exp == 8'h00;
    endfunction

    function automatic logic fp_is_inf(input fp32_t v);
        return (v.exp == 8'hFF) && (v.frac == 23'd0);
    endfunction

    function automatic logic fp_is_nan(input fp32_t v);
        return (v.exp == 8'hFF) && (v.frac != 23'd0);
    endfunction

endpackage

// File: rtl/fpu_multiplication_seq_if.sv
// Request/result bundle of the sequential multiplier.
interface fpu_multiplication_seq_if;
    logic        start;
    logic [31:0] operand_normalized_ieee_a;
    logic [31:0] operand_normalized_ieee_b;
    logic [31:0] final_product;
    logic        busy;
    logic        done;

    modport master (
        output start, operand_normalized_ieee_a, operand_normalized_ieee_b,
        input  final_product, busy, done
    );

    modport slave (
        input  start, operand_normalized_ieee_a, operand_normalized_ieee_b,
        output final_product, busy, done
    );
endinterface

// File: rtl/fpu_norm_round.sv
// Normalises a 48-bit mantissa product, rounds to nearest-even and packs the
// single-precision result, saturating to infinity or flushing to zero.
module fpu_norm_round
    import fpu_pkg::*;
(
    input  logic [47:0]        product,
    input  logic signed [9:0]  exp_in,
    input  logic               sign,
    output logic [31:0]        result
);
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp_adj;
    logic signed [9:0] exp_fin;

    always_comb begin
        mant    = product[45:23];
        guard   = product[22];
        sticky  = |product[21:0];
        exp_adj = exp_in;
        if (product[47]) begin
            mant    = product[46:24];
            guard   = product[23];
            sticky  = |product[22:0];
            exp_adj = exp_in + 10'sd1;
        end

        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, round_up};
        // A carry out leaves the fraction bits at zero, so only the exponent moves.
        exp_fin  = mant_rnd[23] ? exp_adj + 10'sd1 : exp_adj;

        if (exp_fin >= 10'sd255)
            result = {sign, FP_POS_INF[30:0]};
        else if (exp_fin <= 10'sd0)
            result = {sign, 31'd0};
        else
            result = {sign, exp_fin[7:0], mant_rnd[22:0]};
    end
endmodule

// File: rtl/fpu_multiplication_seq.sv
// Iterative single-precision multiplier: shift-and-add mantissa product at one
// bit per clock, then normalise/round; special operands bypass the loop.
module fpu_multiplication_seq
    import fpu_pkg::*;
#(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic                     clk,
    input  logic                     rst,
    fpu_multiplication_seq_if.slave  bus
);
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_SPECIAL = 3'(SPECIAL);
    localparam logic [2:0] ST_MUL     = 3'(MUL);
    localparam logic [2:0] ST_NORM    = 3'(NORM);
    localparam logic [2:0] ST_DONE    = 3'(DONE);

    logic [2:0]        state_reg, state_next;
    logic [4:0]        cnt_reg;
    logic [PROD_W-1:0] acc_reg;
    logic [PROD_W-1:0] mcand_reg;
    logic [MANT_W-1:0] mplier_reg;
    fp32_t             a_reg, b_reg;
    logic [31:0]       product_reg;

    fp32_t             in_a, in_b;
    logic              in_special;
    logic [31:0]       special_result;
    logic signed [9:0] exp_sum;
    logic              sign_mul;
    logic [31:0]       norm_result;

    assign in_a       = fp32_t'(bus.operand_normalized_ieee_a);
    assign in_b       = fp32_t'(bus.operand_normalized_ieee_b);
    assign in_special = fp_is_zero(in_a) | fp_is_zero(in_b) | (in_a.exp == 8'hFF) | (in_b.exp == 8'hFF);

    assign sign_mul = a_reg.sign ^ b_reg.sign;
    assign exp_sum  = 10'({2'b00, a_reg[FRAC_W +: EXP_W]}) + 10'({2'b00, b_reg[FRAC_W +: EXP_W]}) - 10'(BIAS);

    always_comb begin
        if (fp_is_nan(a_reg) || fp_is_nan(b_reg))
            special_result = FP_NAN;
        else if ((fp_is_inf(a_reg) && fp_is_zero(b_reg)) || (fp_is_zero(a_reg) && fp_is_inf(b_reg)))
            special_result = FP_NAN;
        else if (fp_is_inf(a_reg) || fp_is_inf(b_reg))
            special_result = {sign_mul, FP_POS_INF[30:0]};
        else
            special_result = {sign_mul, 31'd0};
    end

    fpu_norm_round u_norm_round (
        .product (acc_reg),
        .exp_in  (exp_sum),
        .sign    (sign_mul),
        .result  (norm_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (bus.start) state_next = in_special ? ST_SPECIAL : ST_MUL;
            ST_SPECIAL: state_next = ST_DONE;
            ST_MUL:     if (cnt_reg == 5'd1) state_next = ST_NORM;
            ST_NORM:    state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 5'd0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            product_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (bus.start) begin
                    a_reg      <= in_a;
                    b_reg      <= in_b;
                    acc_reg    <= '0;
                    mcand_reg  <= {{MANT_W{1'b0}}, 1'b1, in_a.frac};
                    mplier_reg <= {1'b1, in_b.frac};
                    cnt_reg    <= 5'(MANT_W);
                end
                ST_MUL: begin
                    if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg - 5'd1;
                end
                ST_SPECIAL: product_reg <= special_result;
                ST_NORM:    product_reg <= norm_result;
                default: ;
            endcase
        end
    end

    assign bus.final_product = product_reg;
    assign bus.busy          = (state_reg != ST_IDLE);
    assign bus.done          = (state_reg == ST_DONE);
endmodule

// File: tb/tb_fpu_multiplication_seq.sv
// Scoreboard bench for the sequential multiplier: expected products are queued
// at issue and retired on done, with latency, busy, pulse and reset checks.
module tb_fpu_multiplication_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_multiplication_seq_if bus ();

    fpu_multiplication_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, expv);
        end
    endtask

    // Issue one operation and follow it to completion. inject_at > 0 pulses a
    // bogus start on that edge count while the operation is in flight.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int exp_lat, input int inject_at);
        int   edges;
        logic got;
        logic busy_ok;
        logic [31:0] expect_v;
        edges   = 0;
        got     = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.operand_normalized_ieee_a = a;
        bus.operand_normalized_ieee_b = b;
        exp_q.push_back(expv);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.operand_normalized_ieee_a = $urandom;
        bus.operand_normalized_ieee_b = $urandom;
        while (!got && edges < 40) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (!bus.busy) busy_ok = 1'b0;
                bus.start = (edges == inject_at);
                if (edges == inject_at) begin
                    bus.operand_normalized_ieee_a = 32'h3F80_0000;
                    bus.operand_normalized_ieee_b = 32'h3F80_0000;
                end
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        expect_v = exp_q.pop_front();
        if (got) begin
            check({tag, " product"}, bus.final_product, expect_v);
            check({tag, " busy"}, {31'd0, busy_ok & bus.busy}, 32'd1);
            $display("op %s: a=%h b=%h -> %h (expected %h) in %0d edges",
                     tag, a, b, bus.final_product, expect_v, edges);
            @(negedge clk);
            check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
            check({tag, " hold"}, bus.final_product, expect_v);
        end
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.operand_normalized_ieee_a = 32'd0;
        bus.operand_normalized_ieee_b = 32'd0;
        #2;
        check("reset product", bus.final_product, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("1.5x2.0",    32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 26, 0);
        run_op("-2.5x4.0",   32'hC020_0000, 32'h4080_0000, 32'hC120_0000, 26, 5);
        run_op("rne",        32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 26, 0);
        run_op("inf*0",      32'h7F80_0000, 32'h0000_0000, 32'h7F80_0001, 2, 0);
        run_op("0*-inf",     32'h0000_0000, 32'hFF80_0000, 32'h7F80_0001, 2, 0);
        run_op("-inf*2",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2, 0);
        run_op("-0*1",       32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 2, 0);
        run_op("nan*1",      32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0001, 2, 0);
        run_op("denorm*1",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 2, 0);
        run_op("overflow",   32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 26, 0);
        run_op("underflow",  32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 26, 0);
        run_op("-1x-1",      32'hBF80_0000, 32'hBF80_0000, 32'h3F80_0000, 26, 0);
        run_op("3x3",        32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 26, 0);

        // Abort a multiply part way through with reset.
        @(negedge clk);
        bus.start = 1'b1;
        bus.operand_normalized_ieee_a = 32'h3FC0_0000;
        bus.operand_normalized_ieee_b = 32'h4000_0000;
        exp_q.push_back(32'h4040_0000);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("abort product", bus.final_product, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);
        $display("op abort: reset at cycle 10, done pulses seen %0d", done_seen);

        run_op("after reset", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 26, 0);
        check("queue drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
